axi_lite_gpio_irq: RTL

Second-generation AXI4-Lite GPIO controller. It supports 1-4 channels, each 1-32 bits wide, with per-pin direction. It adds input synchronisers, atomic SET/CLR output writes, per-pin rising/falling edge interrupt detection with W1C status, and a single level interrupt output. It sits on the peripheral AXI4-Lite bus beside the existing GPIO and replaces it where interrupts or more channels are needed.

---
 rtl/axi_lite_gpio_irq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_gpio_irq.sv
// axi_lite_gpio_irq
//   AXI4-Lite GPIO controller with 1-4 channels of 1-32 pins each.
//   Per-pin direction, atomic SET/CLR writes, synchronised inputs,
//   per-pin rise/fall edge capture into W1C STATUS, and one registered
//   level interrupt gated by GIE.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   s_axi_aw*/w*/b*    AXI4-Lite write channels (awprot ignored)
//   s_axi_ar*/r*       AXI4-Lite read channels (arprot ignored)
//   gpio_i             asynchronous pin inputs, [channel][pin]
//   gpio_o             DATA register per channel
//   gpio_t             ~DIR per channel (1 = pin tristated)
//   irq                GIE & (any STATUS bit set), registered
module axi_lite_gpio_irq #(
  parameter int GPIO_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [ADDR_WIDTH-1:0]                   s_axi_awaddr,
  input  logic [2:0]                              s_axi_awprot,
  input  logic                                    s_axi_awvalid,
  output logic                                    s_axi_awready,
  input  logic [31:0]                             s_axi_wdata,
  input  logic [3:0]                              s_axi_wstrb,
  input  logic                                    s_axi_wvalid,
  output logic                                    s_axi_wready,
  output logic [1:0]                              s_axi_bresp,
  output logic                                    s_axi_bvalid,
  input  logic                                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                   s_axi_araddr,
  input  logic [2:0]                              s_axi_arprot,
  input  logic                                    s_axi_arvalid,
  output logic                                    s_axi_arready,
  output logic [31:0]                             s_axi_rdata,
  output logic [1:0]                              s_axi_rresp,
  output logic                                    s_axi_rvalid,
  input  logic                                    s_axi_rready,
  input  logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] gpio_i,
  output logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] gpio_o,
  output logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] gpio_t,
  output logic                                    irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_gpio_width
    $error("axi_lite_gpio_irq: GPIO_WIDTH must be 1..32");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 4) begin : g_bad_num_channels
    $error("axi_lite_gpio_irq: NUM_CHANNELS must be 1..4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("axi_lite_gpio_irq: SYNC_STAGES must be 2..3");
  end
  if (ADDR_WIDTH < 8) begin : g_bad_addr_width
    $error("axi_lite_gpio_irq: ADDR_WIDTH must be at least 8");
  end

  typedef logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] bank_t;

  typedef struct packed {
    logic       ok;
    logic       gie;
    logic [1:0] ch;
    logic [2:0] off;
  } dec_t;

  // Word address 0x00-0x1F selects channel/offset, 0x20 is GIE; anything
  // else, a reserved offset, or a missing channel is unmapped.
  function automatic dec_t addr_decode(input logic hi, input logic [5:0] w);
    dec_t d;
    d.ch  = w[4:3];
    d.off = w[2:0];
    d.gie = !hi && (w == 6'h20);
    d.ok  = d.gie || (!hi && !w[5] && (int'(d.ch) < NUM_CHANNELS) && (d.off != 3'd7));
    return d;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  bank_t data_q, dir_q, rise_en_q, fall_en_q, status_q;
  bank_t data_d, dir_d, rise_en_d, fall_en_d, status_d;
  bank_t w1c, rise, fall, sync_i, prev_p;
  bank_t sync_p [SYNC_STAGES];
  logic  gie_q;
  logic  irq_q;

  dec_t            wr_dec, rd_dec;
  logic            wr_fire, wr_ch_hit;
  logic [31:0]     wr_mask32;
  logic [GPIO_WIDTH-1:0] wr_msk, wr_bits;
  logic [31:0]     rd_val;
  logic            unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_dec    = addr_decode(|(s_axi_awaddr >> 8), s_axi_awaddr[7:2]);
  assign rd_dec    = addr_decode(|(s_axi_araddr >> 8), s_axi_araddr[7:2]);
  assign wr_fire   = s_axi_awready;
  assign wr_ch_hit = wr_fire && wr_dec.ok && !wr_dec.gie;
  assign wr_mask32 = strb_mask(s_axi_wstrb);
  assign wr_msk    = GPIO_WIDTH'(wr_mask32);
  assign wr_bits   = GPIO_WIDTH'(s_axi_wdata & wr_mask32);

  // ---- input synchroniser stages, then prev_p for edge detection ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign sync_i = sync_p[SYNC_STAGES-1];
  assign rise   = sync_i & ~prev_p & ~dir_q & rise_en_q;
  assign fall   = ~sync_i & prev_p & ~dir_q & fall_en_q;

  always_comb begin
    data_d    = data_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_ch_hit && int'(wr_dec.ch) == c) begin
        case (wr_dec.off)
          3'd0: data_d[c]    = (data_q[c] & ~wr_msk) | wr_bits;
          3'd1: dir_d[c]     = (dir_q[c] & ~wr_msk) | wr_bits;
          3'd2: data_d[c]    = data_q[c] | wr_bits;
          3'd3: data_d[c]    = data_q[c] & ~wr_bits;
          3'd4: rise_en_d[c] = (rise_en_q[c] & ~wr_msk) | wr_bits;
          3'd5: fall_en_d[c] = (fall_en_q[c] & ~wr_msk) | wr_bits;
          3'd6: w1c[c]       = wr_bits;
          default: ;
        endcase
      end
    end
    // A new edge re-sets a bit even if it is being cleared this cycle.
    status_d = (status_q & ~w1c) | rise | fall;
  end

  // ---- register bank and interrupt stage ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      gie_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      if (wr_fire && wr_dec.gie && s_axi_wstrb[0]) gie_q <= s_axi_wdata[0];
      irq_q     <= gie_q & (|status_q);
    end
  end

  assign gpio_o = data_q;
  assign gpio_t = ~dir_q;
  assign irq    = irq_q;

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_dec.ok && !rd_dec.gie && int'(rd_dec.ch) == c) begin
        case (rd_dec.off)
          3'd0: rd_val = 32'((dir_q[c] & data_q[c]) | (~dir_q[c] & sync_i[c]));
          3'd1: rd_val = 32'(dir_q[c]);
          3'd4: rd_val = 32'(rise_en_q[c]);
          3'd5: rd_val = 32'(fall_en_q[c]);
          3'd6: rd_val = 32'(status_q[c]);
          default: rd_val = '0;
        endcase
      end
    end
    if (rd_dec.gie) rd_val = {31'b0, gie_q};
  end

  // ---- write channel: accept pulse, then response ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      if (s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_dec.ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // ---- read channel: accept pulse, then data ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= 1'b0;
      if (s_axi_arvalid && !s_axi_rvalid && !s_axi_arready) s_axi_arready <= 1'b1;
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_dec.ok ? rd_val : 32'h0;
        s_axi_rresp  <= rd_dec.ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
